// File: rtl/imm_pkg.sv
// Shared types for the immediate-extension path: format selects, raw/extended words and the
// output-buffer state.
package imm_pkg;

  localparam logic IMM_SRC_I16 = 1'b0;
  localparam logic IMM_SRC_J26 = 1'b1;

  typedef logic [25:0] imm_raw_t;
  typedef logic [31:0] imm_word_t;

  typedef enum logic {
    BufEmpty,
    BufFull
  } buf_state_t;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Requester/response bundle for imm_ext_arbiter. The arbiter uses the slave view; requesters
// and the downstream consumer together form the master view.
interface imm_ext_arbiter_if
  import imm_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
);

  logic     [N_REQ-1:0] req_valid;
  imm_raw_t [N_REQ-1:0] req_num;
  logic     [N_REQ-1:0] req_imm_src;
  logic     [N_REQ-1:0] req_ready;
  logic                 resp_valid;
  imm_word_t            resp_data;
  logic     [ID_W-1:0]  resp_id;
  logic                 resp_ready;

  modport master (
    output req_valid, req_num, req_imm_src, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_num, req_imm_src, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/sign_extend.sv
// Sign-extends a 16-bit or 26-bit immediate field to 32 bits; bits above the field are ignored.
module sign_extend
  import imm_pkg::*;
(
  input  imm_raw_t  num_in,
  input  logic      imm_src,
  output imm_word_t num_out
);

  always_comb begin
    num_out = {{16{num_in[15]}}, num_in[15:0]};
    if (imm_src == IMM_SRC_J26) begin
      num_out = {{6{num_in[25]}}, num_in};
    end
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one sign_extend unit between N_REQ requesters, with a one-entry
// registered output buffer that honours downstream backpressure.
module imm_ext_arbiter
  import imm_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input logic               clk,
  input logic               rst_n,
  imm_ext_arbiter_if.slave  bus
);

  buf_state_t            state_q;
  imm_word_t             data_q;
  logic     [ID_W-1:0]   id_q;
  logic     [ID_W-1:0]   ptr_q;

  logic     [ID_W-1:0]   winner;
  logic     [ID_W-1:0]   cand;
  logic     [ID_W-1:0]   ptr_next;
  logic                  found;
  logic                  can_accept;
  logic                  accept;
  logic     [N_REQ-1:0]  req_ready;
  imm_raw_t              win_num;
  logic                  win_src;
  imm_word_t             ext_word;

  // Scan ptr, ptr+1, ... modulo N_REQ; the first valid requester wins.
  always_comb begin
    winner = ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    ptr_next   = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
    can_accept = (state_q == BufEmpty) || bus.resp_ready;
    accept     = rst_n && can_accept && found;
    req_ready  = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
    win_num = bus.req_num[winner];
    win_src = bus.req_imm_src[winner];
  end

  sign_extend u_sign_extend (
    .num_in  (win_num),
    .imm_src (win_src),
    .num_out (ext_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BufEmpty;
      data_q  <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else if (accept) begin
      state_q <= BufFull;
      data_q  <= ext_word;
      id_q    <= winner;
      ptr_q   <= ptr_next;
    end else if (bus.resp_ready) begin
      // Drain without a new accept; data and id keep their last value.
      state_q <= BufEmpty;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = (state_q == BufFull);
  assign bus.resp_data  = data_q;
  assign bus.resp_id    = id_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed and randomized checks of imm_ext_arbiter with N_REQ=2 and N_REQ=4 instances.
module tb_imm_ext_arbiter;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_ext_arbiter_if #(.N_REQ(2)) bus2 ();
  imm_ext_arbiter_if #(.N_REQ(4)) bus4 ();

  imm_ext_arbiter #(.N_REQ(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  imm_ext_arbiter #(.N_REQ(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  int n_checks = 0;
  int n_pass   = 0;

  imm_raw_t    d_num [2];
  logic        d_src [2];
  imm_raw_t    e_num [4];
  logic [3:0]  e_src;
  logic [31:0] exp_data;
  logic [31:0] exp_id;
  imm_raw_t    num_a;

  // Reference model state for the randomized phase
  logic        m_valid;
  logic [31:0] m_data;
  int          m_id;
  int          m_next;
  int          g;
  int          mi;
  logic        can;
  logic        rr;
  logic [3:0]  pend;
  logic [3:0]  exp_rdy;

  // Sign extension computed arithmetically from the field value.
  function automatic logic [31:0] ext(input imm_raw_t n, input logic s);
    longint v;
    if (!s) begin
      v = n % 65536;
      if (v >= 32768) v -= 65536;
    end else begin
      v = n;
      if (v >= 2 ** 25) v -= 2 ** 26;
    end
    return 32'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rand2();
    for (int i = 0; i < 2; i++) begin
      d_num[i] = 26'($urandom);
      d_src[i] = 1'($urandom);
    end
  endtask

  task automatic step2(input logic [1:0] v, input logic r, input logic rn);
    @(negedge clk);
    rst_n           = rn;
    bus2.req_valid  = v;
    bus2.resp_ready = r;
    for (int i = 0; i < 2; i++) begin
      bus2.req_num[i]     = d_num[i];
      bus2.req_imm_src[i] = d_src[i];
    end
    #1;
  endtask

  task automatic step4(input logic [3:0] v, input logic r, input logic rn);
    @(negedge clk);
    rst_n           = rn;
    bus4.req_valid  = v;
    bus4.resp_ready = r;
    for (int i = 0; i < 4; i++) begin
      bus4.req_num[i]     = e_num[i];
      bus4.req_imm_src[i] = e_src[i];
    end
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bus2.req_valid   = '1;
    bus2.resp_ready  = 1'b1;
    bus2.req_num     = '0;
    bus2.req_imm_src = '0;
    bus4.req_valid   = '1;
    bus4.resp_ready  = 1'b1;
    bus4.req_num     = '0;
    bus4.req_imm_src = '0;
    for (int i = 0; i < 4; i++) e_num[i] = 26'($urandom);
    e_src = 4'($urandom);

    // Reset held with every requester valid
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_ready2", bus2.req_ready, 0);
      chk("rst_ready4", bus4.req_ready, 0);
      chk("rst_valid", bus2.resp_valid, 0);
      chk("rst_data", bus2.resp_data, 0);
      chk("rst_id", bus2.resp_id, 0);
    end
    bus4.req_valid = '0;

    // Extension values, first grant to requester 0
    num_a    = 26'b01111111111111100001111000;
    d_num[0] = num_a;
    d_src[0] = 1'b0;
    d_num[1] = '0;
    d_src[1] = 1'b0;
    step2(2'b01, 1'b1, 1'b1);
    chk("first_grant", bus2.req_ready, 2'b01);
    d_src[0] = 1'b1;
    step2(2'b01, 1'b1, 1'b1);
    chk("ext16_valid", bus2.resp_valid, 1);
    chk("ext16_data", bus2.resp_data, 32'hFFFFF878);
    chk("ext16_id", bus2.resp_id, 0);
    chk("ext16_ready", bus2.req_ready, 2'b01);
    rand2();
    step2(2'b10, 1'b1, 1'b1);
    chk("ext26_data", bus2.resp_data, 32'h01FFF878);
    chk("ext26_id", bus2.resp_id, 0);
    chk("grant1_ready", bus2.req_ready, 2'b10);
    exp_data = ext(d_num[1], d_src[1]);
    exp_id   = 1;

    // Fairness: both valid, grants alternate 0,1,... with no bubble
    for (int k = 0; k < 6; k++) begin
      rand2();
      step2(2'b11, 1'b1, 1'b1);
      chk("rr_valid", bus2.resp_valid, 1);
      chk("rr_id", bus2.resp_id, exp_id);
      chk("rr_data", bus2.resp_data, exp_data);
      chk("rr_ready", bus2.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      exp_data = ext(d_num[k % 2], d_src[k % 2]);
      exp_id   = k % 2;
    end

    // Backpressure: outputs hold, nothing accepted
    rand2();
    repeat (4) begin
      step2(2'b11, 1'b0, 1'b1);
      chk("stall_ready", bus2.req_ready, 2'b00);
      chk("stall_valid", bus2.resp_valid, 1);
      chk("stall_data", bus2.resp_data, exp_data);
      chk("stall_id", bus2.resp_id, exp_id);
    end
    step2(2'b11, 1'b1, 1'b1);
    chk("unstall_ready", bus2.req_ready, 2'b01);
    exp_data = ext(d_num[0], d_src[0]);
    step2(2'b10, 1'b1, 1'b1);
    chk("unstall_data", bus2.resp_data, exp_data);
    chk("unstall_id", bus2.resp_id, 0);
    chk("grant1b_ready", bus2.req_ready, 2'b10);
    exp_data = ext(d_num[1], d_src[1]);
    step2(2'b00, 1'b1, 1'b1);
    chk("last_valid", bus2.resp_valid, 1);
    chk("last_id", bus2.resp_id, 1);
    step2(2'b00, 1'b1, 1'b1);
    chk("drain_valid", bus2.resp_valid, 0);
    chk("drain_data", bus2.resp_data, exp_data);
    chk("drain_id", bus2.resp_id, 1);

    // Reset while full and stalled
    rand2();
    step2(2'b01, 1'b1, 1'b1);
    chk("pre_rst_ready", bus2.req_ready, 2'b01);
    step2(2'b00, 1'b0, 1'b1);
    chk("pre_rst_valid", bus2.resp_valid, 1);
    step2(2'b01, 1'b0, 1'b0);
    step2(2'b01, 1'b1, 1'b0);
    chk("midrst_ready", bus2.req_ready, 2'b00);
    chk("midrst_valid", bus2.resp_valid, 0);
    chk("midrst_data", bus2.resp_data, 0);
    chk("midrst_id", bus2.resp_id, 0);
    step2(2'b00, 1'b1, 1'b1);
    chk("post_rst_valid", bus2.resp_valid, 0);
    step2(2'b00, 1'b1, 1'b1);
    chk("no_spurious", bus2.resp_valid, 0);

    // Pointer wrap on N_REQ=4 with requests only on 1 and 3
    for (int k = 0; k < 6; k++) begin
      step4(4'b1010, 1'b1, 1'b1);
      chk("wrap_ready", bus4.req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
      if (k > 0) begin
        chk("wrap_id", bus4.resp_id, (k % 2 == 1) ? 1 : 3);
        chk("wrap_data", bus4.resp_data,
            (k % 2 == 1) ? ext(e_num[1], e_src[1]) : ext(e_num[3], e_src[3]));
      end
    end
    step4(4'b1111, 1'b1, 1'b1);
    chk("wrap_to_0", bus4.req_ready, 4'b0001);

    // Randomized phase against the reference model
    step4(4'b0000, 1'b1, 1'b0);
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
    m_next  = 0;
    pend    = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          e_num[i] = 26'($urandom);
          e_src[i] = 1'($urandom);
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      step4(pend, rr, 1'b1);
      can = !m_valid || rr;
      g   = -1;
      for (int off = 0; off < 4; off++) begin
        mi = (m_next + off) % 4;
        if (g < 0 && pend[mi]) g = mi;
      end
      exp_rdy = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("rnd_ready", bus4.req_ready, exp_rdy);
      chk("rnd_valid", bus4.resp_valid, m_valid);
      chk("rnd_data", bus4.resp_data, m_data);
      chk("rnd_id", bus4.resp_id, m_id);
      if (can && g >= 0) begin
        m_valid = 1'b1;
        m_data  = ext(e_num[g], e_src[g]);
        m_id    = g;
        m_next  = (g + 1) % 4;
        pend[g] = 1'b0;
      end else if (rr) begin
        m_valid = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imm_ext_arbiter.md
# imm_ext_arbiter

Round-robin arbiter that shares one `sign_extend` unit between `N_REQ` requesters, such as decode immediate generation and the branch/jump target unit. The arbiter grants one request per cycle through a valid/ready handshake and drives the shared extender's `num_in` and `imm_src`. It registers the 32-bit result together with the requester ID in a one-entry output buffer that honours downstream backpressure. It sits between the decode stage and the execute-stage operand muxes.

## Interface
- `N_REQ`, default 2: number of requesters, valid range 2–8.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester ID.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid` input `N_REQ`: per-requester request valid.
- `req_num` input `N_REQ`×26: per-requester raw immediate field.
- `req_imm_src` input `N_REQ`: per-requester format select.
  - 0: extend `[15:0]`.
  - 1: extend `[25:0]`.
- `req_ready` output `N_REQ`: request accepted this cycle when both valid and ready are high.
- `resp_valid` output 1: `resp_data` and `resp_id` are valid.
- `resp_data` output 32: sign-extended immediate.
- `resp_id` output `ID_W`: index of the requester that owns `resp_data`.
- `resp_ready` input 1: downstream consumes the response when both valid and ready are high.

## Operation
- **Extension rules (combinational, inside `sign_extend`):**
  - `imm_src`=0 → `{{16{num[15]}}, num[15:0]}`.
  - `imm_src`=1 → `{{6{num[25]}}, num[25:0]}`.
  - Bits above the selected field are ignored.
- **Round-robin arbitration:**
  - Priority pointer `ptr` has `ID_W` bits.
  - The winner is the first `i` with `req_valid[i]`=1, scanning `ptr`, `ptr+1`, …, wrapping modulo `N_REQ`.
- **Output buffer:**
  - `can_accept = !resp_valid || resp_ready`.
  - `req_ready[i] = can_accept && (i == winner) && req_valid[i]`. At most one bit is set; the others are 0.
- **On accept:**
  - Next cycle `resp_valid`=1, `resp_data` = extension of the winner's inputs, `resp_id` = winner.
  - `ptr` ← winner+1, wrapping from `N_REQ-1` to 0.
- **Drain:**
  - If `resp_valid && resp_ready` with no new accept, `resp_valid`→0 next cycle.
  - `resp_data` and `resp_id` keep their last value.
- **Stall:** while `resp_valid && !resp_ready`, all of `req_ready`=0 and the `resp_*` outputs hold stable.
- **Simultaneous drain and accept:** the buffer reloads with the new result; `resp_valid` stays 1 with no bubble.
- **Requester rule:** once `req_valid[i]` is raised it stays high, with `req_num[i]` and `req_imm_src[i]` stable, until accepted. The arbiter does not depend on this beyond correctness of the data it captures.
- **No valid requests:** `ptr` is unchanged and nothing is accepted.
- **Output-buffer states:** EMPTY (`resp_valid`=0) and FULL (`resp_valid`=1).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on drain with no accept.
  - FULL → FULL on a stall, or on drain plus accept.

## Timing
- Latency is one cycle from the accepting edge to `resp_valid`.
- Sustained throughput is one response per cycle while `resp_ready`=1.
- **`req_ready` paths:**
  - Combinational from `req_valid`, `ptr`, `resp_valid` and `resp_ready`.
  - No combinational path from `req_num` or `req_imm_src` to any output.
- **Reset values when `rst_n`=0 at an edge:** `resp_valid`=0, `resp_data`=32'h0, `resp_id`=0, `ptr`=0.
- **`req_ready` during reset:** forced to all zeros in any cycle where `rst_n`=0.
- **Reset mid-operation:** a pending response is discarded with no handshake, and arbitration restarts at requester 0.

## Structure
- **Shared package `imm_pkg`:**
  - `IMM_SRC_I16`=1'b0 and `IMM_SRC_J26`=1'b1.
  - `imm_raw_t` (logic [25:0]) and `imm_word_t` (logic [31:0]).
- **Sub-module:**
  - Instantiate the existing `sign_extend(num_in, imm_src, num_out)` once, fed by the winner mux.
  - There are no other sub-modules.
  - Arbitration, the pointer and the output register live in `imm_ext_arbiter`.

## Test plan
- **Reset:**
  - Stimulus: hold `rst_n`=0 for 3 cycles with all `req_valid`=1.
  - Response: `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_id`=0.
  - After release the first grant goes to requester 0.
- **Extension values:**
  - Stimulus: req0 with `num`=26'b01111111111111100001111000 and `imm_src`=0.
  - Response: `resp_data`=32'hFFFFF878, `resp_id`=0, one cycle later.
  - Stimulus: the same `num` with `imm_src`=1.
  - Response: 32'h01FFF878.
- **Round-robin fairness:**
  - Stimulus: both requesters held valid for 6 cycles with `resp_ready`=1.
  - Response: `resp_id` sequence 0,1,0,1,0,1 with no idle cycles.
- **Backpressure:**
  - Stimulus: `resp_ready`=0 for 4 cycles while the buffer is FULL.
  - Response: `req_ready`=0 and `resp_data`/`resp_id` stable throughout.
  - Stimulus: raise `resp_ready`.
  - Response: the same cycle the next request is accepted, and the new result appears the following cycle.
- **Pointer wrap (`N_REQ`=4):**
  - Stimulus: requests only on 3 and 1.
  - Response: grants alternate 1,3,1,3, and `ptr` wraps from 3 to 0.
- **Reset mid-operation:**
  - Stimulus: assert `rst_n`=0 while FULL and stalled.
  - Response: `resp_valid`=0 next cycle, with no spurious response after release.
